seq_detector_param: RTL and testbench

//   Runtime-programmable serial bit-sequence detector, successor to the fixed-pattern seq_detector.

---
 rtl/seq_detector_param.sv | 93 +++++++++
 tb/tb_seq_detector_param.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-sequence detector with overlap control,
// registered match pulse and a saturating match counter.
module seq_detector_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT     = MAX_LEN'(4'b0110),
  parameter int                 DEF_LEN     = 4,
  parameter bit                 DEF_OVERLAP = 1'b1,
  localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               x_valid,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic               ovl;
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;

  logic [MAX_LEN-1:0] hist_n;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_inc;
  logic               sample;
  logic               hit;
  logic               cfg_ok;

  always_comb begin
    sample   = x_valid && !cfg_we;
    // newest bit lands in hist[0]; the top bit falls off
    hist_n   = MAX_LEN'({hist, x});
    fill_inc = (fill == MAX_LEN_L) ? fill : fill + 1'b1;
    mask     = ~({MAX_LEN{1'b1}} << len);
    hit      = sample && (fill_inc >= len) && (((hist_n ^ pat) & mask) == '0);
    cfg_ok   = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pat       <= DEF_PAT;
      len       <= LEN_W'(DEF_LEN);
      ovl       <= DEF_OVERLAP;
      hist      <= '0;
      fill      <= '0;
      z         <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      z       <= hit;
      cfg_err <= 1'b0;

      // a config write always consumes the cycle, accepted or not
      if (cfg_we) begin
        if (cfg_ok) begin
          pat  <= cfg_pat;
          len  <= cfg_len;
          ovl  <= cfg_overlap;
          fill <= '0;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (x_valid) begin
        hist <= hist_n;
        fill <= (hit && !ovl) ? '0 : fill_inc;
      end

      if (cnt_clr) begin
        match_cnt <= hit ? CNT_W'(1) : '0;
        cnt_sat   <= 1'b0;
      end else if (hit && (match_cnt != CNT_MAX)) begin
        match_cnt <= match_cnt + 1'b1;
        if (match_cnt == CNT_MAX - 1'b1)
          cnt_sat <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: two instances (8-bit and 2-bit counter) share
// one stimulus stream and are compared each cycle against a queue-based model.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       x;
  logic       x_valid;
  logic       cfg_we;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       cnt_clr;

  logic       z_a, sat_a, err_a;
  logic [7:0] cnt_a;
  logic       z_b, sat_b, err_b;
  logic [1:0] cnt_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detector_param dut_a (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cfg_we(cfg_we),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .z(z_a), .match_cnt(cnt_a), .cnt_sat(sat_a), .cfg_err(err_a)
  );

  seq_detector_param #(.CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cfg_we(cfg_we),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .z(z_b), .match_cnt(cnt_b), .cnt_sat(sat_b), .cfg_err(err_b)
  );

  // reference model: bits received since the last restart, newest at the back
  bit         q[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_z, m_err;
  int         c8, c2;
  bit         s8, s2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit i_x, i_v, i_we, input logic [7:0] i_pat,
                       input int i_len, input bit i_ovl, i_clr, i_rst);
    bit hit;
    hit   = 1'b0;
    m_err = 1'b0;
    if (!i_rst) begin
      q.delete();
      m_pat = 8'b0110; m_len = 4; m_ovl = 1'b1;
      c8 = 0; c2 = 0; s8 = 1'b0; s2 = 1'b0;
    end else begin
      if (i_we) begin
        if (i_len >= 1 && i_len <= 8) begin
          m_pat = i_pat; m_len = i_len; m_ovl = i_ovl;
          q.delete();
        end else begin
          m_err = 1'b1;
        end
      end else if (i_v) begin
        q.push_back(i_x);
        if (q.size() > 8) void'(q.pop_front());
        if (q.size() >= m_len) begin
          hit = 1'b1;
          for (int i = 0; i < m_len; i++)
            if (q[q.size() - 1 - i] != m_pat[i]) hit = 1'b0;
        end
        if (hit && !m_ovl) q.delete();
      end
      if (i_clr) begin
        c8 = hit ? 1 : 0; c2 = hit ? 1 : 0; s8 = 1'b0; s2 = 1'b0;
      end else if (hit) begin
        if (c8 < 255) c8++;
        if (c2 < 3) c2++;
        if (c8 == 255) s8 = 1'b1;
        if (c2 == 3) s2 = 1'b1;
      end
    end
    m_z = hit;
  endtask

  task automatic step(input bit i_x, i_v, i_we, input logic [7:0] i_pat,
                      input logic [3:0] i_len, input bit i_ovl, i_clr, i_rst);
    @(negedge clk);
    x = i_x; x_valid = i_v; cfg_we = i_we; cfg_pat = i_pat; cfg_len = i_len;
    cfg_overlap = i_ovl; cnt_clr = i_clr; reset = i_rst;
    @(posedge clk);
    model(i_x, i_v, i_we, i_pat, int'(i_len), i_ovl, i_clr, i_rst);
    #1;
    chk("z_a", z_a, m_z);
    chk("cnt_a", cnt_a, c8);
    chk("sat_a", sat_a, s8);
    chk("err_a", err_a, m_err);
    chk("z_b", z_b, m_z);
    chk("cnt_b", cnt_b, c2);
    chk("sat_b", sat_b, s2);
  endtask

  task automatic bit_in(input bit b);
    step(b, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic do_rst();
    step(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input bit o, input bit clr);
    step(1'b0, 1'b0, 1'b1, p, l, o, clr, 1'b1);
  endtask

  typedef struct {
    bit x;
    bit z_ovl;
    int cnt_ovl;
    bit z_novl;
    int cnt_novl;
  } vec_t;
  vec_t tbl[12];

  task automatic run_stream(input bit novl, input string tag);
    for (int i = 0; i < 12; i++) begin
      bit_in(tbl[i].x);
      chk({tag, "_z"}, z_a, novl ? tbl[i].z_novl : tbl[i].z_ovl);
      chk({tag, "_cnt"}, cnt_a, novl ? tbl[i].cnt_novl : tbl[i].cnt_ovl);
    end
  endtask

  initial begin
    tbl[0]  = '{0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 1, 1, 1};
    tbl[5]  = '{1, 0, 1, 0, 1};
    tbl[6]  = '{1, 0, 1, 0, 1};
    tbl[7]  = '{0, 1, 2, 0, 1};
    tbl[8]  = '{0, 0, 2, 0, 1};
    tbl[9]  = '{1, 0, 2, 0, 1};
    tbl[10] = '{1, 0, 2, 0, 1};
    tbl[11] = '{0, 1, 3, 1, 2};

    reset = 1'b0; x = 1'b0; x_valid = 1'b0; cfg_we = 1'b0; cfg_pat = '0;
    cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;

    // reset state and default-pattern overlapping stream
    do_rst();
    chk("rst_z", z_a, 1'b0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_err", err_a, 1'b0);
    run_stream(1'b0, "t1");

    // non-overlapping mode, counter cleared by the same write
    cfg(8'b0110, 4'd4, 1'b0, 1'b1);
    chk("t2_cfg_cnt", cnt_a, 0);
    run_stream(1'b1, "t2");

    // single-bit pattern against the 2-bit counter
    cfg(8'b1, 4'd1, 1'b1, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      bit_in(1'b1);
      chk("t3_z", z_b, 1'b1);
      chk("t3_cnt", cnt_b, (i < 3) ? i : 3);
      chk("t3_sat", sat_b, i >= 3);
    end
    step(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
    chk("t3_clr_cnt", cnt_b, 0);
    chk("t3_clr_sat", sat_b, 1'b0);
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b1);
    chk("t3_resat", sat_b, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
    chk("t3_clrhit_cnt", cnt_b, 1);
    chk("t3_clrhit_sat", sat_b, 1'b0);

    // illegal lengths are rejected and leave the default config intact
    do_rst();
    cfg(8'hFF, 4'd0, 1'b0, 1'b0);
    chk("t4_err0", err_a, 1'b1);
    idle();
    chk("t4_err_pulse", err_a, 1'b0);
    cfg(8'hFF, 4'd9, 1'b0, 1'b0);
    chk("t4_err9", err_a, 1'b1);
    run_stream(1'b0, "t4");

    // reset mid-stream restarts the fill
    do_rst();
    bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
    do_rst();
    chk("t5_z", z_a, 1'b0);
    chk("t5_cnt", cnt_a, 0);
    chk("t5_sat", sat_a, 1'b0);
    chk("t5_err", err_a, 1'b0);
    bit_in(1'b0);
    chk("t5_nohit", z_a, 1'b0);

    // idle gaps between bits
    do_rst();
    begin
      bit b4[4] = '{0, 1, 1, 0};
      for (int i = 0; i < 4; i++) begin
        bit_in(b4[i]);
        chk("t6_bit_z", z_a, i == 3);
        for (int k = 0; k < 3; k++) begin
          idle();
          chk("t6_idle_z", z_a, 1'b0);
        end
      end
    end
    chk("t6_cnt", cnt_a, 1);

    // sample dropped on a rejected write: history still holds 0,1,1
    do_rst();
    bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
    step(1'b0, 1'b1, 1'b1, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
    chk("t6_rej_z", z_a, 1'b0);
    chk("t6_rej_err", err_a, 1'b1);
    bit_in(1'b0);
    chk("t6_rej_hit", z_a, 1'b1);

    // sample dropped on an accepted write: fill restarts
    bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
    step(1'b0, 1'b1, 1'b1, 8'b0110, 4'd4, 1'b1, 1'b0, 1'b1);
    chk("t6_acc_z", z_a, 1'b0);
    bit_in(1'b0);
    chk("t6_acc_nohit", z_a, 1'b0);

    // full-width pattern
    cfg(8'b1011_0010, 4'd8, 1'b1, 1'b1);
    begin
      logic [7:0] p8 = 8'b1011_0010;
      for (int i = 7; i >= 0; i--) bit_in(p8[i]);
    end
    chk("len8_z", z_a, 1'b1);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 1) begin
        do_rst();
      end else if (r < 4) begin
        logic [3:0] l;
        l = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(1, 3));
        step(1'($urandom), 1'($urandom), 1'b1, 8'($urandom), l, 1'($urandom),
             ($urandom_range(0, 9) == 0), 1'b1);
      end else begin
        step(1'($urandom), ($urandom_range(0, 3) != 0), 1'b0, 8'h00, 4'd0, 1'b0,
             ($urandom_range(0, 49) == 0), 1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
